// File: rtl/tof_frame_streamer.sv
// ---------------------------------------------------------------------------
// tof_frame_streamer : round-robin ToF sensor frame reader -> valid/ready stream
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tof_frame_streamer #(
  parameter int          NB_OF_SENSORS = 8,
  parameter int          NB_ZONES      = 64,
  parameter logic [7:0]  HEADER_TAG    = 8'hA5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NB_OF_SENSORS-1:0] data_ready,
  output logic [2:0]               rd_sensor,
  output logic [5:0]               rd_zone,
  input  logic [15:0]              rd_data,
  output logic [15:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic [NB_OF_SENSORS-1:0] overrun,
  input  logic                     overrun_clr,
  output logic [15:0]              frame_cnt
);

  localparam logic [5:0] LAST_ZONE = 6'(NB_ZONES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } state_t;

  state_t                   state, state_nxt;
  logic [NB_OF_SENSORS-1:0] pending, pending_nxt;
  logic [NB_OF_SENSORS-1:0] overrun_nxt;
  logic [2:0]               rr_ptr, rr_ptr_nxt;
  logic [2:0]               rd_sensor_nxt;
  logic [5:0]               rd_zone_nxt;
  logic [15:0]              out_data_nxt;
  logic                     out_valid_nxt;
  logic                     out_last_nxt;
  logic                     busy_nxt;
  logic [15:0]              frame_cnt_nxt;
  logic                     grant_found;
  logic [2:0]               grant_idx;
  logic [2:0]               cand;
  logic                     accept;

  // Round-robin search starts just after the last granted sensor.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 3'd0;
    cand        = 3'd0;
    for (int k = 1; k <= NB_OF_SENSORS; k++) begin
      cand = rr_ptr + 3'(k);
      if (!grant_found && pending[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign accept = out_valid & out_ready;

  always_comb begin
    state_nxt     = state;
    pending_nxt   = pending;
    overrun_nxt   = (overrun_clr ? '0 : overrun) | (data_ready & pending);
    rr_ptr_nxt    = rr_ptr;
    rd_sensor_nxt = rd_sensor;
    rd_zone_nxt   = rd_zone;
    out_data_nxt  = out_data;
    out_valid_nxt = out_valid;
    out_last_nxt  = out_last;
    busy_nxt      = busy;
    frame_cnt_nxt = frame_cnt;

    case (state)
      IDLE: begin
        if (grant_found) begin
          state_nxt              = HEADER;
          pending_nxt[grant_idx] = 1'b0;
          rr_ptr_nxt             = grant_idx;
          rd_sensor_nxt          = grant_idx;
          rd_zone_nxt            = 6'd0;
          busy_nxt               = 1'b1;
          out_valid_nxt          = 1'b1;
          out_last_nxt           = 1'b0;
          out_data_nxt           = {HEADER_TAG, 5'b0, grant_idx};
        end
      end
      HEADER: begin
        if (accept) begin
          out_data_nxt = rd_data;
          out_last_nxt = (rd_zone == LAST_ZONE);
          rd_zone_nxt  = rd_zone + 6'd1;
          state_nxt    = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          if (out_last) begin
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
            busy_nxt      = 1'b0;
            frame_cnt_nxt = frame_cnt + 16'd1;
            state_nxt     = IDLE;
          end else begin
            out_data_nxt = rd_data;
            out_last_nxt = (rd_zone == LAST_ZONE);
            rd_zone_nxt  = rd_zone + 6'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A new request in the grant cycle must survive the clear.
    pending_nxt = pending_nxt | data_ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pending   <= '0;
      overrun   <= '0;
      rr_ptr    <= 3'd7;
      rd_sensor <= 3'd0;
      rd_zone   <= 6'd0;
      out_data  <= 16'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      overrun   <= overrun_nxt;
      rr_ptr    <= rr_ptr_nxt;
      rd_sensor <= rd_sensor_nxt;
      rd_zone   <= rd_zone_nxt;
      out_data  <= out_data_nxt;
      out_valid <= out_valid_nxt;
      out_last  <= out_last_nxt;
      busy      <= busy_nxt;
      frame_cnt <= frame_cnt_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tof_frame_streamer.sv
// ---------------------------------------------------------------------------
// tb_tof_frame_streamer : randomized bench with a frame-level reference model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tof_frame_streamer;

  localparam int NZ = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_ready;
  logic [2:0]  rd_sensor;
  logic [5:0]  rd_zone;
  logic [15:0] rd_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic [7:0]  overrun;
  logic        overrun_clr;
  logic [15:0] frame_cnt;

  logic [15:0] mem [8][NZ];
  assign rd_data = mem[rd_sensor][rd_zone];

  always #5 clk = ~clk;

  tof_frame_streamer dut (
    .clk         (clk),
    .reset       (reset),
    .data_ready  (data_ready),
    .rd_sensor   (rd_sensor),
    .rd_zone     (rd_zone),
    .rd_data     (rd_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .frame_cnt   (frame_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frames, pending requests and counters at the level of the rules
  logic [7:0]  m_pend, m_ov, last_pulse;
  logic [2:0]  m_rr, m_sensor;
  logic        m_in_frame, m_idle_iv, last_clr;
  int          m_idx;
  logic [15:0] m_fcnt;
  int          ready_pct;

  function automatic logic [2:0] rr_pick(input logic [7:0] p, input logic [2:0] after);
    for (int k = 1; k <= 8; k++) begin
      int s;
      s = (int'(after) + k) % 8;
      if (p[s]) return 3'(s);
    end
    return 3'd0;
  endfunction

  function automatic logic [15:0] exp_word();
    if (m_idx == 0) return {8'hA5, 5'b0, m_sensor};
    return mem[m_sensor][m_idx-1];
  endfunction

  task automatic model_reset();
    m_pend = 0; m_ov = 0; m_rr = 3'd7; m_sensor = 0;
    m_in_frame = 0; m_idle_iv = 1; m_idx = 0; m_fcnt = 0;
    last_pulse = 0; last_clr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; data_ready = 0; out_ready = 0; overrun_clr = 0;
    #1;
    check_eq("rst_out_valid", 16'(out_valid), 16'd0);
    check_eq("rst_out_last",  16'(out_last),  16'd0);
    check_eq("rst_busy",      16'(busy),      16'd0);
    check_eq("rst_out_data",  out_data,       16'd0);
    check_eq("rst_rd_sensor", 16'(rd_sensor), 16'd0);
    check_eq("rst_rd_zone",   16'(rd_zone),   16'd0);
    check_eq("rst_overrun",   16'(overrun),   16'd0);
    check_eq("rst_frame_cnt", frame_cnt,      16'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One clock: check what the last edge produced, then drive the next edge.
  task automatic cycle(input logic [7:0] dr, input logic clr);
    logic [7:0] old;
    logic       rdy;
    @(negedge clk);
    old = m_pend;
    if (m_idle_iv && old != 0) begin
      m_sensor   = rr_pick(old, m_rr);
      m_rr       = m_sensor;
      m_pend     = (old & ~(8'b1 << m_sensor)) | last_pulse;
      m_in_frame = 1;
      m_idx      = 0;
    end else begin
      m_pend = old | last_pulse;
    end
    m_ov = (last_clr ? 8'h00 : m_ov) | (last_pulse & old);

    check_eq("overrun",   16'(overrun),   16'(m_ov));
    check_eq("frame_cnt", frame_cnt,      m_fcnt);
    check_eq("busy",      16'(busy),      16'(m_in_frame));
    check_eq("out_valid", 16'(out_valid), 16'(m_in_frame));
    check_eq("out_last",  16'(out_last),  16'(m_in_frame && m_idx == NZ));
    if (m_in_frame) begin
      check_eq("out_data",  out_data,       exp_word());
      check_eq("rd_sensor", 16'(rd_sensor), 16'(m_sensor));
    end
    m_idle_iv = !m_in_frame;

    rdy = ($urandom_range(99) < ready_pct);
    out_ready = rdy; data_ready = dr; overrun_clr = clr;
    last_pulse = dr; last_clr = clr;
    if (m_in_frame && rdy) begin
      if (m_idx == NZ) begin
        m_in_frame = 0;
        m_fcnt     = m_fcnt + 16'd1;
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while ((m_in_frame || m_pend != 0 || last_pulse != 0) && n < budget) begin
      cycle(8'h00, 1'b0);
      n++;
    end
    check_eq("drain_timeout", 16'(n >= budget), 16'd0);
    cycle(8'h00, 1'b0);
    cycle(8'h00, 1'b0);
  endtask

  task automatic fill_mem();
    for (int s = 0; s < 8; s++)
      for (int z = 0; z < NZ; z++)
        mem[s][z] = 16'($urandom);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; data_ready = 0; out_ready = 0; overrun_clr = 0;
    ready_pct = 100;
    model_reset();
    fill_mem();
    do_reset();

    // single sensor frame at full rate
    cycle(8'h04, 1'b0);
    run_idle(1000);
    check_eq("t1_frame_cnt", frame_cnt, 16'd1);
    check_eq("t1_busy", 16'(busy), 16'd0);

    // all sensors at once, then wrap-around order
    fill_mem();
    cycle(8'hFF, 1'b0);
    run_idle(2000);
    cycle(8'h81, 1'b0);
    run_idle(1000);
    check_eq("t2_frame_cnt", frame_cnt, 16'd11);

    // back-pressure during a frame
    fill_mem();
    ready_pct = 70;
    cycle(8'h04, 1'b0);
    run_idle(2000);

    // overrun from a double request during another sensor's frame
    ready_pct = 100;
    cycle(8'h20, 1'b0);
    for (int n = 0; n < 20 && !(m_in_frame && m_idx >= 3); n++) cycle(8'h00, 1'b0);
    cycle(8'h08, 1'b0);
    repeat (5) cycle(8'h00, 1'b0);
    cycle(8'h08, 1'b0);
    run_idle(1000);
    check_eq("t4_overrun", 16'(overrun), 16'h0008);
    cycle(8'h00, 1'b1);
    cycle(8'h00, 1'b0);
    check_eq("t4_overrun_clr", 16'(overrun), 16'h0000);

    // reset in the middle of a frame, then a clean restart
    cycle(8'h02, 1'b0);
    for (int n = 0; n < 40 && !(m_in_frame && m_idx >= 11); n++) cycle(8'h00, 1'b0);
    do_reset();
    cycle(8'h02, 1'b0);
    cycle(8'h00, 1'b0);
    cycle(8'h00, 1'b0);
    check_eq("t5_header", out_data, 16'hA501);
    run_idle(1000);

    // random requests, clears and back-pressure
    ready_pct = 80;
    for (int n = 0; n < 1500; n++)
      cycle(($urandom_range(99) < 3) ? 8'($urandom) : 8'h00, ($urandom_range(99) < 2));
    run_idle(6000);

    // frame counter wrap
    ready_pct = 100;
    force dut.frame_cnt = 16'hFFFF;
    m_fcnt = 16'hFFFF;
    cycle(8'h00, 1'b0);
    cycle(8'h00, 1'b0);
    release dut.frame_cnt;
    cycle(8'h00, 1'b0);
    cycle(8'h01, 1'b0);
    run_idle(1000);
    check_eq("t6_wrap", frame_cnt, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
